// File: rtl/read_memory.sv
// read_memory: streams a latched address range out of the 256x8 S-array RAM.
// Read requests are paced by a credit check so that every outstanding read
// already has a slot reserved in the output FIFO. The FIFO absorbs the RAM
// read latency and downstream back-pressure without losing a byte.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// READING | issuing reads from addr_cnt up to last_q as credit allows
// DRAIN   | all reads issued; waiting for pipeline and FIFO to empty
// DONE    | finish pulse for one cycle, then back to IDLE
module read_memory #(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] first_addr,
    input  logic [7:0] last_addr,
    output logic       mem_rd_en,
    output logic [7:0] address_out,
    input  logic [7:0] data_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       finish
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PEND_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE,
        READING,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              addr_cnt;
    logic [7:0]              last_q;
    logic [READ_LATENCY-1:0] vld;
    logic [7:0]              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [PEND_W-1:0]       pending;
    logic                    credit_ok;
    logic                    push;
    logic                    pop;

    assign push      = vld[READ_LATENCY-1];
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    // Slots already claimed: the read on the bus this cycle, reads in the
    // latency pipe and bytes sitting in the FIFO. A pop in this cycle is not
    // counted, so the credit decision depends on registers only.
    always_comb begin
        pending = PEND_W'(fifo_count) + PEND_W'(mem_rd_en);
        for (int i = 0; i < READ_LATENCY; i++) begin
            pending = pending + PEND_W'(vld[i]);
        end
    end

    assign credit_ok = (pending < PEND_W'(FIFO_DEPTH));

    // Sequencing FSM; the first read is issued on the same edge that accepts
    // start, which is safe because the pipe and FIFO are empty in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_rd_en   <= 1'b0;
            address_out <= 8'h00;
            addr_cnt    <= 8'h00;
            last_q      <= 8'h00;
            busy        <= 1'b0;
            finish      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_rd_en <= 1'b0;
                    finish    <= 1'b0;
                    if (start) begin
                        last_q      <= last_addr;
                        mem_rd_en   <= 1'b1;
                        address_out <= first_addr;
                        addr_cnt    <= first_addr + 8'd1;
                        busy        <= 1'b1;
                        state       <= (first_addr == last_addr) ? DRAIN : READING;
                    end
                end
                READING: begin
                    if (credit_ok) begin
                        mem_rd_en   <= 1'b1;
                        address_out <= addr_cnt;
                        addr_cnt    <= addr_cnt + 8'd1;
                        if (addr_cnt == last_q) begin
                            state <= DRAIN;
                        end
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    mem_rd_en <= 1'b0;
                    if (!mem_rd_en && (vld == '0) && (fifo_count == '0)) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-latency tracker: the last stage marks data_in as valid this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= mem_rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // First-word-fall-through buffer; credit pacing guarantees a free slot on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= data_in;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_read_memory.sv
// Bench for read_memory: three instances (read latency 1, 2, 3) share the
// stimulus; each has its own RAM read pipe. Expected byte streams come from
// the range rule: bytes = ((last - first) mod 256) + 1, data = ram[first + k].
module tb_read_memory;

    localparam int NI     = 3;
    localparam int DEPTH  = 4;
    localparam int BUDGET = 4000;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       start      = 1'b0;
    logic       out_ready  = 1'b0;
    logic [7:0] first_addr = 8'h00;
    logic [7:0] last_addr  = 8'h00;

    logic       mem_rd_en_a [NI];
    logic [7:0] address_a   [NI];
    logic [7:0] data_in_a   [NI];
    logic [7:0] out_data_a  [NI];
    logic       out_valid_a [NI];
    logic       busy_a      [NI];
    logic       finish_a    [NI];

    logic [7:0] ram       [256];
    logic [7:0] exp_bytes [256];
    int         exp_n = 0;
    logic       mon_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [7:0] pipe [LAT];

        read_memory #(.READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .first_addr (first_addr),
            .last_addr  (last_addr),
            .mem_rd_en  (mem_rd_en_a[g]),
            .address_out(address_a[g]),
            .data_in    (data_in_a[g]),
            .out_data   (out_data_a[g]),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready),
            .busy       (busy_a[g]),
            .finish     (finish_a[g])
        );

        // RAM read port: data appears LAT cycles after the request; junk otherwise.
        always @(posedge clk) begin
            pipe[0] <= mem_rd_en_a[g] ? ram[address_a[g]] : 8'($urandom);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign data_in_a[g] = pipe[LAT-1];
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         start_cyc = -1;
    int         got_n [NI], fin_n [NI], rd_n [NI], pop_n [NI];
    int         rd_before_pop [NI], max_out [NI], stall_err [NI], bad_n [NI], bad_idx [NI];
    int         first_valid_cyc [NI], first_pop_cyc [NI], last_pop_cyc [NI], fin_cyc [NI];
    logic [7:0] bad_got [NI], bad_exp [NI], first_byte [NI], prev_data [NI];
    logic       prev_stall [NI];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            start_cyc = -1;
            for (int g = 0; g < NI; g++) begin
                got_n[g] = 0; fin_n[g] = 0; rd_n[g] = 0; pop_n[g] = 0;
                rd_before_pop[g] = 0; max_out[g] = 0; stall_err[g] = 0;
                bad_n[g] = 0; bad_idx[g] = 0; first_valid_cyc[g] = -1;
                first_pop_cyc[g] = -1; last_pop_cyc[g] = -1; fin_cyc[g] = -1;
                bad_got[g] = 8'h00; bad_exp[g] = 8'h00; first_byte[g] = 8'h00;
                prev_data[g] = 8'h00; prev_stall[g] = 1'b0;
            end
        end else begin
            if (rst_n && start && start_cyc < 0 && !busy_a[0]) start_cyc = cyc;
            for (int g = 0; g < NI; g++) begin
                if (out_valid_a[g] && first_valid_cyc[g] < 0) first_valid_cyc[g] = cyc;
                if (prev_stall[g] && out_data_a[g] != prev_data[g]) stall_err[g]++;
                prev_stall[g] = out_valid_a[g] && !out_ready;
                prev_data[g]  = out_data_a[g];
                if (mem_rd_en_a[g]) begin
                    rd_n[g]++;
                    if (pop_n[g] == 0) rd_before_pop[g]++;
                end
                if (out_valid_a[g] && out_ready) begin
                    if (got_n[g] == 0) first_byte[g] = out_data_a[g];
                    if (got_n[g] >= exp_n || out_data_a[g] != exp_bytes[got_n[g]]) begin
                        if (bad_n[g] == 0) begin
                            bad_idx[g] = got_n[g];
                            bad_got[g] = out_data_a[g];
                            bad_exp[g] = (got_n[g] < exp_n) ? exp_bytes[got_n[g]] : 8'h00;
                        end
                        bad_n[g]++;
                    end
                    got_n[g]++;
                    pop_n[g]++;
                    if (first_pop_cyc[g] < 0) first_pop_cyc[g] = cyc;
                    last_pop_cyc[g] = cyc;
                end
                if (rd_n[g] - pop_n[g] > max_out[g]) max_out[g] = rd_n[g] - pop_n[g];
                if (finish_a[g]) begin
                    fin_n[g]++;
                    fin_cyc[g] = cyc;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s: got %0d, required <= %0d", name, got, lim);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_pass(input logic [7:0] fa, input logic [7:0] la,
                             input bit ident, input bit poke);
        int n;
        for (int i = 0; i < 256; i++) ram[i] = ident ? 8'(i) : 8'($urandom);
        if (poke) ram[fa] = 8'hC3;
        n = ((int'(la) - int'(fa) + 256) % 256) + 1;
        for (int j = 0; j < n; j++) exp_bytes[j] = ram[(int'(fa) + j) % 256];
        exp_n = n;
    endtask

    task automatic run_pass(input string name, input logic [7:0] fa, input logic [7:0] la,
                            input bit ident, input bit poke, input int mode,
                            input int ign_at, input int exp_count);
        int k;
        bit done;
        @(posedge clk); #1;
        load_pass(fa, la, ident, poke);
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr    = 1'b0;
        first_addr = fa;
        last_addr  = la;
        start      = 1'b1;
        out_ready  = (mode != 2);
        k = 0;
        done = 1'b0;
        while (!done && k < BUDGET) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (ign_at > 0 && k == ign_at) begin
                start = 1'b1; first_addr = 8'h80; last_addr = 8'h81;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (k >= 20) && (k % 2 == 0);
            endcase
            done = 1'b1;
            for (int g = 0; g < NI; g++) if (fin_n[g] == 0 || busy_a[g]) done = 1'b0;
        end
        check($sformatf("%s pass_completed", name), int'(done), 1);
        if (!done) begin
            do_reset();
            return;
        end
        repeat (3) begin @(posedge clk); #1; end
        for (int g = 0; g < NI; g++) begin
            string p;
            p = $sformatf("%s L%0d", name, g + 1);
            check({p, " byte_count"}, got_n[g], exp_count);
            check({p, " read_count"}, rd_n[g], exp_count);
            check({p, " order_errors"}, bad_n[g], 0);
            if (bad_n[g] != 0)
                $display("  %s first bad byte #%0d: got %02h, required %02h", p, bad_idx[g], bad_got[g], bad_exp[g]);
            check({p, " finish_pulses"}, fin_n[g], 1);
            check({p, " busy_at_end"}, int'(busy_a[g]), 0);
            check({p, " stalled_data_changes"}, stall_err[g], 0);
            check_le({p, " max_outstanding"}, max_out[g], DEPTH);
            if (mode == 2) check_le({p, " reads_before_first_pop"}, rd_before_pop[g], DEPTH);
            if (mode == 0) begin
                check({p, " first_valid_latency"}, first_valid_cyc[g] - start_cyc, g + 3);
                check({p, " finish_after_last_pop"}, fin_cyc[g] - last_pop_cyc[g], 2);
                if (g == 0) check({p, " stream_span"}, last_pop_cyc[g] - first_pop_cyc[g], exp_count - 1);
            end
            if (poke) check({p, " first_byte"}, int'(first_byte[g]), 8'hC3);
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] fa;
        logic [7:0] la;
        bit         ident;
        bit         poke;
        int         mode;
        int         ign_at;
        int         exp_count;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"full_pass",     8'h00, 8'hFF, 1'b1, 1'b0, 0, 0,  256};
        vecs[1] = '{"wrap_range",    8'hFE, 8'h01, 1'b0, 1'b0, 0, 0,  4};
        vecs[2] = '{"single_byte",   8'h5A, 8'h5A, 1'b0, 1'b1, 0, 0,  1};
        vecs[3] = '{"back_pressure", 8'h00, 8'h3F, 1'b1, 1'b0, 2, 0,  64};
        vecs[4] = '{"random_ready",  8'h00, 8'hFF, 1'b1, 1'b0, 1, 0,  256};
        vecs[5] = '{"start_ignored", 8'h20, 8'h3F, 1'b0, 1'b0, 0, 10, 32};

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        mon_clr = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < NI; g++)
            check($sformatf("L%0d reset_outputs", g + 1),
                  int'({mem_rd_en_a[g], address_a[g], out_valid_a[g], out_data_a[g], busy_a[g], finish_a[g]}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_clr = 1'b0;

        for (int v = 0; v < 6; v++)
            run_pass(vecs[v].name, vecs[v].fa, vecs[v].la, vecs[v].ident, vecs[v].poke,
                     vecs[v].mode, vecs[v].ign_at, vecs[v].exp_count);

        // Abort a pass with reset, then run a fresh short pass.
        @(posedge clk); #1;
        load_pass(8'h00, 8'hFF, 1'b1, 1'b0);
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; first_addr = 8'h00; last_addr = 8'hFF; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++)
            check($sformatf("L%0d midpass_reset_outputs", g + 1),
                  int'({mem_rd_en_a[g], address_a[g], out_valid_a[g], out_data_a[g], busy_a[g], finish_a[g]}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("L%0d aborted_pass_finish", g + 1), fin_n[g], 0);
            check($sformatf("L%0d idle_after_abort", g + 1), int'(busy_a[g]), 0);
        end
        run_pass("after_reset", 8'h10, 8'h12, 1'b1, 1'b0, 0, 0, 3);

        // Randomized ranges and ready patterns against the range rule.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] fa, la;
            int mode, n;
            fa   = 8'($urandom);
            la   = fa + 8'($urandom_range(0, 90));
            mode = $urandom_range(0, 2);
            n    = ((int'(la) - int'(fa) + 256) % 256) + 1;
            run_pass($sformatf("rand%0d", r), fa, la, 1'b0, 1'b0, mode, 0, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/read_memory.md
Name: read_memory

Overview:
- Sequential reader for the 256x8 on-chip S-array RAM: reads a latched address range and streams the bytes out over a valid/ready handshake.
- Sits between the S-array RAM read port and downstream consumers: result/debug dump, checker, or PRGA keystream stage.
- Absorbs the RAM's fixed read latency with a small first-word-fall-through FIFO, so downstream back-pressure never loses a byte.

Parameters:
READ_LATENCY, 1, clock cycles from mem_rd_en/address_out to valid data_in (supported 1..3)
FIFO_DEPTH, 4, output buffer entries (power of 2, >= READ_LATENCY+1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a read pass; sampled only in IDLE
first_addr  input  8  first address read; latched on accepted start
last_addr  input  8  last address read, inclusive; latched on accepted start
mem_rd_en  output  1  read request to RAM this cycle
address_out  output  8  RAM read address, valid when mem_rd_en=1
data_in  input  8  RAM read data, valid READ_LATENCY cycles after its request
out_data  output  8  byte at FIFO head
out_valid  output  1  out_data holds a valid byte
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  high in every state except IDLE
finish  output  1  one-cycle pulse when the pass is complete

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_rd_en=0, address_out=0, out_valid=0, out_data=0, busy=0, finish=0. FIFO emptied, in-flight pipeline cleared, counters zeroed. Reset mid-pass abandons the pass; no finish pulse.
- States: IDLE, READING, DRAIN, DONE.
  - IDLE: start=1 -> latch first_addr/last_addr, load the address counter with first_addr, go to READING.
  - READING: issue a read whenever credit allows. When the issued address equals last_addr -> DRAIN in the same cycle as that issue.
  - DRAIN: no new reads. Go to DONE when the pipeline is empty, the FIFO is empty, and no push is pending.
  - DONE: finish=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Credit rule: issue (mem_rd_en=1) only if in_flight + fifo_count < FIFO_DEPTH. A same-cycle pop does not add credit; this keeps the path registered. The FIFO can never overflow.
- Address arithmetic: 8-bit counter, +1 per issue, modulo 256. last_addr < first_addr wraps through 8'hFF to 8'h00. first_addr == last_addr reads exactly one byte. first_addr=00, last_addr=FF reads all 256 bytes.
- Bytes in pass = ((last_addr - first_addr) mod 256) + 1.
- In-flight tracking: READ_LATENCY-stage valid shift register fed by mem_rd_en. Its output pushes data_in into the FIFO in that cycle.
- FIFO: first-word fall-through.
  - out_valid = (fifo_count != 0); out_data = head entry.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop is legal; count unchanged.
  - out_data is unchanged while out_valid=1 and out_ready=0.
- Ordering: bytes leave in address order, none dropped or duplicated.
- Best-case latency: start accepted at cycle 0, first mem_rd_en at cycle 1, first out_valid at cycle 1+READ_LATENCY+1.
- With out_ready held at 1 and READ_LATENCY=1: one byte per cycle sustained. finish asserts 2 cycles after the last byte is accepted (DRAIN detects empty, then DONE).
- busy=1 in READING, DRAIN and DONE.
- out_ready is don't-care while out_valid=0.

Test Plan:
- Full pass:
  - Stimulus: RAM preloaded S[i]=i, first=00, last=FF, out_ready=1.
  - Required: 256 bytes 00..FF in order, one per cycle after the initial latency; a single finish pulse; busy drops with the return to IDLE.
- Wrap range:
  - Stimulus: first=FE, last=01.
  - Required: exactly 4 bytes at addresses FE, FF, 00, 01, carrying the data stored at those addresses.
- Single byte:
  - Stimulus: first=last=5A, RAM[5A]=C3.
  - Required: one transfer of C3, then finish; mem_rd_en high for exactly 1 cycle.
- Back-pressure:
  - Stimulus: out_ready=0 for 20 cycles after start, then toggle 1/0 each cycle.
  - Required: mem_rd_en issues at most FIFO_DEPTH reads before the first pop; out_data stable while stalled; no byte lost or duplicated; order intact.
- Latency sweep:
  - Stimulus: READ_LATENCY=2 and 3 with random out_ready.
  - Required: same byte stream as the full-pass case; fifo_count never exceeds FIFO_DEPTH.
- Reset and start-ignore:
  - Stimulus: rst_n pulsed low mid-pass, then a new start with first=10, last=12.
  - Required: outputs at reset values immediately; no finish from the aborted pass; new pass returns bytes 10, 11, 12.
  - Stimulus: start asserted while busy=1.
  - Required: start ignored; the running pass is unaffected.
